pipe_mips32: RTL and testbench

Five-stage pipelined (IF, ID, EX, MEM, WB) 32-bit MIPS-style processor core with a unified word-addressed instruction/data memory and a 32-entry register file. It runs on a single clock and supports a reduced ALU/load/store/branch/halt instruction set. The core is self-contained: programs and data are preloaded hierarchically into internal arrays, and results are inspected the same way. It is the top-level compute block of the pipelined-processor design.

---
 rtl/pipe_mips32.sv | 133 +++++++++++++
 tb/tb_pipe_mips32.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage pipelined MIPS-style core with unified word memory.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (pipeline flushed, PC = 0)
//   halted : high once an HLT has retired; core frozen until reset
//   pc     : current fetch address (word index)
module pipe_mips32 (
  input  logic        clk,
  input  logic        rst,
  output logic        halted,
  output logic [31:0] pc
);
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND = 6'd2, OR = 6'd3, SLT = 6'd4, MUL = 6'd5;
  localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
  localparam logic [5:0] BNEZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63;
  // Bubble word: opcode 62 is undefined, so it decodes as nothing
  localparam logic [31:0] NOP = 32'hf800_0000;
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:1023];
  logic [31:0] PC, pc_d;
  logic        HALTED, halted_d, TAKEN_BRANCH, taken_d;
  logic [31:0] ifid_ir_q, ifid_ir_d, ifid_npc_q, ifid_npc_d;
  logic [31:0] idex_ir_q, idex_ir_d, idex_npc_q, idex_npc_d, idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [31:0] exmem_ir_q, exmem_ir_d, exmem_alu_q, exmem_alu_d, exmem_b_q, exmem_b_d;
  logic [31:0] memwb_ir_q, memwb_ir_d, memwb_res_q, memwb_res_d;
  logic [5:0]  ifid_op, idex_op, exmem_op, memwb_op;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, exmem_rd, wb_rd;
  logic [31:0] fa, fb, imm, alu;
  logic        exmem_fw, wb_we, taken, stop, unused_ok;

  function automatic logic wr(input logic [5:0] op);
    return op <= MUL || (op >= ADDI && op <= SLTI) || op == LW;
  endfunction

  function automatic logic [4:0] dst(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
    return op <= MUL ? rd : rt;
  endfunction

  assign halted    = HALTED;
  assign pc        = PC;
  assign ifid_op   = ifid_ir_q[31:26];
  assign idex_op   = idex_ir_q[31:26];
  assign exmem_op  = exmem_ir_q[31:26];
  assign memwb_op  = memwb_ir_q[31:26];
  assign id_rs     = ifid_ir_q[25:21];
  assign id_rt     = ifid_ir_q[20:16];
  assign ex_rs     = idex_ir_q[25:21];
  assign ex_rt     = idex_ir_q[20:16];
  assign exmem_rd  = dst(exmem_op, exmem_ir_q[20:16], exmem_ir_q[15:11]);
  assign wb_rd     = dst(memwb_op, memwb_ir_q[20:16], memwb_ir_q[15:11]);
  // Load data is not ready in MEM, so only ALU results forward from EX/MEM
  assign exmem_fw  = wr(exmem_op) && exmem_op != LW && exmem_rd != 5'd0;
  assign wb_we     = wr(memwb_op) && wb_rd != 5'd0;
  assign imm       = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};
  assign fa        = (exmem_fw && exmem_rd == ex_rs) ? exmem_alu_q : (wb_we && wb_rd == ex_rs) ? memwb_res_q : idex_a_q;
  assign fb        = (exmem_fw && exmem_rd == ex_rt) ? exmem_alu_q : (wb_we && wb_rd == ex_rt) ? memwb_res_q : idex_b_q;
  assign unused_ok = ^{exmem_ir_q[25:21], exmem_ir_q[10:0], memwb_ir_q[25:21], memwb_ir_q[10:0]};

  always_comb begin
    case (idex_op)
      ADD:          alu = fa + fb;
      SUB:          alu = fa - fb;
      AND:          alu = fa & fb;
      OR:           alu = fa | fb;
      SLT:          alu = 32'($signed(fa) < $signed(fb));
      MUL:          alu = fa * fb;
      ADDI, LW, SW: alu = fa + imm;
      SUBI:         alu = fa - imm;
      SLTI:         alu = 32'($signed(fa) < $signed(imm));
      default:      alu = 32'd0;
    endcase
  end

  always_comb begin
    taken = (idex_op == BNEZ && fa != 32'd0) || (idex_op == BEQZ && fa == 32'd0);
    // Fetch stays stopped while an HLT is anywhere from ID to WB
    stop = ifid_op == HLT || idex_op == HLT || exmem_op == HLT || memwb_op == HLT;
    pc_d = taken ? idex_npc_q + imm : stop ? PC : PC + 32'd1;
    ifid_ir_d = (taken || stop) ? NOP : Mem[PC[9:0]];
    ifid_npc_d = PC + 32'd1;
    idex_ir_d = taken ? NOP : ifid_ir_q;
    idex_npc_d = ifid_npc_q;
    // Write-through register file: a same-cycle WB write is seen by ID
    idex_a_d = id_rs == 5'd0 ? 32'd0 : (wb_we && wb_rd == id_rs) ? memwb_res_q : Reg[id_rs];
    idex_b_d = id_rt == 5'd0 ? 32'd0 : (wb_we && wb_rd == id_rt) ? memwb_res_q : Reg[id_rt];
    exmem_ir_d = idex_ir_q;
    exmem_alu_d = alu;
    exmem_b_d = fb;
    memwb_ir_d = exmem_ir_q;
    memwb_res_d = exmem_op == LW ? Mem[exmem_alu_q[9:0]] : exmem_alu_q;
    halted_d = HALTED || memwb_op == HLT;
    taken_d = taken;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC <= 32'd0;
      HALTED <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      ifid_ir_q <= NOP;
      ifid_npc_q <= 32'd0;
      idex_ir_q <= NOP;
      idex_npc_q <= 32'd0;
      idex_a_q <= 32'd0;
      idex_b_q <= 32'd0;
      exmem_ir_q <= NOP;
      exmem_alu_q <= 32'd0;
      exmem_b_q <= 32'd0;
      memwb_ir_q <= NOP;
      memwb_res_q <= 32'd0;
    end else if (!HALTED) begin
      PC <= pc_d;
      HALTED <= halted_d;
      TAKEN_BRANCH <= taken_d;
      ifid_ir_q <= ifid_ir_d;
      ifid_npc_q <= ifid_npc_d;
      idex_ir_q <= idex_ir_d;
      idex_npc_q <= idex_npc_d;
      idex_a_q <= idex_a_d;
      idex_b_q <= idex_b_d;
      exmem_ir_q <= exmem_ir_d;
      exmem_alu_q <= exmem_alu_d;
      exmem_b_q <= exmem_b_d;
      memwb_ir_q <= memwb_ir_d;
      memwb_res_q <= memwb_res_d;
    end
  end

  // Register file and memory are never cleared; reset only empties the pipeline
  always_ff @(posedge clk) begin
    if (!HALTED && wb_we) Reg[wb_rd] <= memwb_res_q;
    if (!HALTED && exmem_op == SW) Mem[exmem_alu_q[9:0]] <= exmem_b_q;
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed-program bench for pipe_mips32.
module tb_pipe_mips32;
  localparam logic [31:0] NOP = 32'hf800_0000, HLT = 32'hfc00_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        halted;
  logic [31:0] pc;
  int          n_chk = 0, n_fail = 0, edges = 0, pulses = 0;
  logic [31:0] basic [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

  pipe_mips32 dut (.clk(clk), .rst(rst), .halted(halted), .pc(pc));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] i);
    return {op, s, t, i};
  endfunction

  task automatic clear();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.Reg[i] = 32'd0;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = NOP;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 9; i++) dut.Mem[i] = basic[i];
  endtask

  // Release reset and count edges until halted (edge 1 fetches Mem[0])
  task automatic run(input int max);
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    pulses = 0;
    while (!halted && edges < max) begin
      @(posedge clk);
      #1;
      edges++;
      if (dut.TAKEN_BRANCH) pulses++;
    end
  endtask

  initial begin
    clear();
    check("rst_pc", pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    load_basic();
    run(40);
    check("basic_edges", edges, 32'd13);
    check("basic_r0", dut.Reg[0], 32'd0);
    check("basic_r1", dut.Reg[1], 32'd10);
    check("basic_r2", dut.Reg[2], 32'd20);
    check("basic_r3", dut.Reg[3], 32'd25);
    check("basic_r4", dut.Reg[4], 32'd30);
    check("basic_r5", dut.Reg[5], 32'd55);
    check("basic_pc", pc, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    check("basic_pc_frozen", pc, 32'd9);
    check("basic_halted_hold", {31'd0, halted}, 32'd1);

    clear();
    dut.Mem[0] = ri(6'd10, 5'd0, 5'd1, 16'd5);
    dut.Mem[1] = rr(6'd0, 5'd1, 5'd1, 5'd2);
    dut.Mem[2] = rr(6'd1, 5'd2, 5'd1, 5'd3);
    dut.Mem[3] = HLT;
    run(40);
    check("fwd_edges", edges, 32'd8);
    check("fwd_r2", dut.Reg[2], 32'd10);
    check("fwd_r3", dut.Reg[3], 32'd5);

    clear();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = ri(6'd10, 5'd0, 5'd1, 16'd120);
    dut.Mem[1] = ri(6'd8, 5'd1, 5'd2, 16'd0);
    dut.Mem[2] = rr(6'd3, 5'd3, 5'd3, 5'd3);
    dut.Mem[3] = ri(6'd10, 5'd2, 5'd2, 16'd45);
    dut.Mem[4] = ri(6'd9, 5'd1, 5'd2, 16'd1);
    dut.Mem[5] = HLT;
    run(40);
    check("ls_edges", edges, 32'd10);
    check("ls_r2", dut.Reg[2], 32'd130);
    check("ls_mem121", dut.Mem[121], 32'd130);

    clear();
    dut.Mem[200] = 32'd7;
    dut.Mem[0] = ri(6'd10, 5'd0, 5'd10, 16'd200);
    dut.Mem[1] = ri(6'd8, 5'd10, 5'd3, 16'd0);
    dut.Mem[2] = ri(6'd10, 5'd0, 5'd2, 16'd1);
    dut.Mem[3] = rr(6'd5, 5'd2, 5'd3, 5'd2);
    dut.Mem[4] = ri(6'd11, 5'd3, 5'd3, 16'd1);
    dut.Mem[5] = ri(6'd13, 5'd3, 5'd0, 16'hfffd);
    dut.Mem[6] = ri(6'd10, 5'd5, 5'd5, 16'd1);
    dut.Mem[7] = ri(6'd9, 5'd10, 5'd2, 16'hfffe);
    dut.Mem[8] = HLT;
    run(400);
    check("fact_halted", {31'd0, halted}, 32'd1);
    check("fact_mem198", dut.Mem[198], 32'd5040);
    check("fact_pulses", pulses, 32'd6);
    check("fact_squash_r5", dut.Reg[5], 32'd1);
    check("fact_r3", dut.Reg[3], 32'd0);

    clear();
    dut.Mem[0] = ri(6'd10, 5'd0, 5'd0, 16'd9);
    dut.Mem[1] = ri(6'd10, 5'd0, 5'd1, 16'd3);
    dut.Mem[2] = HLT;
    dut.Mem[3] = ri(6'd10, 5'd0, 5'd6, 16'd77);
    run(40);
    check("r0_edges", edges, 32'd7);
    check("r0_zero", dut.Reg[0], 32'd0);
    check("r0_r1", dut.Reg[1], 32'd3);
    repeat (20) @(posedge clk);
    #1;
    check("freeze_halted", {31'd0, halted}, 32'd1);
    check("freeze_pc", pc, 32'd3);
    check("freeze_r6", dut.Reg[6], 32'd0);

    clear();
    load_basic();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_pc", pc, 32'd0);
    check("mid_halted", {31'd0, halted}, 32'd0);
    check("mid_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_r1", dut.Reg[1], 32'd10);
    check("mid_r2", dut.Reg[2], 32'd20);
    check("mid_r3", dut.Reg[3], 32'd0);
    check("mid_r4", dut.Reg[4], 32'd0);
    run(40);
    check("rerun_edges", edges, 32'd13);
    check("rerun_r3", dut.Reg[3], 32'd25);
    check("rerun_r4", dut.Reg[4], 32'd30);
    check("rerun_r5", dut.Reg[5], 32'd55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
